// File: rtl/rr_burst_scheduler_pkg.sv
// Shared arbitration types and bit-vector helpers for the round-robin schedulers.
// Helpers work on a fixed maximum width; callers zero-extend and truncate.
package arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_e;

    localparam int ARB_MAX_W = 32;
    typedef logic [ARB_MAX_W-1:0] arb_vec_t;

    // Isolate the lowest set bit (two's-complement trick).
    function automatic arb_vec_t ff1(input arb_vec_t v);
        return v & (~v + arb_vec_t'(1));
    endfunction

    // Thermometer with bits 0..p set.
    function automatic arb_vec_t thermo_upto(input int p);
        arb_vec_t ones;
        ones = '1;
        return ~(ones << (p + 1));
    endfunction

    // Bits strictly above position p.
    function automatic arb_vec_t mask_above(input int p);
        return ~thermo_upto(p);
    endfunction

    function automatic int onehot_to_idx(input arb_vec_t oh);
        int idx;
        idx = 0;
        for (int i = 0; i < ARB_MAX_W; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_burst_scheduler_if.sv
// Requester/resource handshake bundle between the clients and the burst scheduler.
interface rr_burst_scheduler_if #(
    parameter int REQ_WIDTH = 4,
    parameter int LEN_WIDTH = 4
);
    localparam int IDX_W = $clog2(REQ_WIDTH);

    logic [REQ_WIDTH-1:0]           req;
    logic [REQ_WIDTH*LEN_WIDTH-1:0] req_len;
    logic                           beat_done;
    logic [REQ_WIDTH-1:0]           gnt;
    logic [IDX_W-1:0]               gnt_id;
    logic                           busy;
    logic                           last;

    modport master (
        output req, req_len, beat_done,
        input  gnt, gnt_id, busy, last
    );

    modport slave (
        input  req, req_len, beat_done,
        output gnt, gnt_id, busy, last
    );
endinterface

// File: rtl/rr_burst_scheduler_pick.sv
// Combinational round-robin pick: first request strictly above ptr, else the
// lowest request overall.
module rr_pick
    import arb_pkg::*;
#(
    parameter  int REQ_WIDTH = 4,
    localparam int IDX_W     = $clog2(REQ_WIDTH)
) (
    input  logic [REQ_WIDTH-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [REQ_WIDTH-1:0] onehot,
    output logic [IDX_W-1:0]     idx,
    output logic                 any
);
    arb_vec_t req_w;
    arb_vec_t masked_w;
    arb_vec_t pick_w;

    always_comb begin
        req_w    = arb_vec_t'(req);
        masked_w = req_w & mask_above(int'(ptr));
        pick_w   = (masked_w != '0) ? ff1(masked_w) : ff1(req_w);
        onehot   = REQ_WIDTH'(pick_w);
        idx      = IDX_W'(onehot_to_idx(pick_w));
        any      = (pick_w != '0);
    end
endmodule

// File: rtl/rr_burst_scheduler.sv
// Round-robin scheduler that holds each grant for a whole burst of req_len+1
// beats; rotation happens only at burst end or when the owner drops its request.
module rr_burst_scheduler
    import arb_pkg::*;
#(
    parameter int REQ_WIDTH = 4,
    parameter int LEN_WIDTH = 4
) (
    input logic                 clk,
    input logic                 reset_n,
    rr_burst_scheduler_if.slave bus
);
    localparam int IDX_W = $clog2(REQ_WIDTH);

    arb_state_e           state_q;
    logic [REQ_WIDTH-1:0] gnt_q;
    logic [IDX_W-1:0]     gnt_id_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [LEN_WIDTH-1:0] count_q;
    logic                 last_q;

    logic [LEN_WIDTH-1:0] len_arr [REQ_WIDTH];
    logic [REQ_WIDTH-1:0] pick_req;
    logic [REQ_WIDTH-1:0] pick_oh;
    logic [IDX_W-1:0]     pick_ptr;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 owner_req;
    logic [LEN_WIDTH-1:0] win_len;

    genvar gi;
    generate
        for (gi = 0; gi < REQ_WIDTH; gi++) begin : g_len
            assign len_arr[gi] = bus.req_len[gi*LEN_WIDTH +: LEN_WIDTH];
        end
    endgenerate

    // While a burst runs, the picker already sees the finisher masked and the
    // pointer at the finisher, so the follow-on grant is ready on the last beat.
    always_comb begin
        pick_req = bus.req;
        pick_ptr = ptr_q;
        if (state_q == GRANT) begin
            pick_req[gnt_id_q] = 1'b0;
            pick_ptr           = gnt_id_q;
        end
    end

    rr_pick #(.REQ_WIDTH(REQ_WIDTH)) u_pick (
        .req    (pick_req),
        .ptr    (pick_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign owner_req = bus.req[gnt_id_q];
    assign win_len   = len_arr[pick_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= IDX_W'(REQ_WIDTH - 1);
            count_q  <= '0;
            last_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        state_q  <= GRANT;
                        gnt_q    <= pick_oh;
                        gnt_id_q <= pick_idx;
                        count_q  <= win_len;
                        last_q   <= (win_len == '0);
                    end
                end
                GRANT: begin
                    // A dropped request wins over any beat in the same cycle.
                    if (!owner_req) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        ptr_q   <= gnt_id_q;
                        count_q <= '0;
                        last_q  <= 1'b0;
                    end else if (bus.beat_done) begin
                        if (count_q == '0) begin
                            ptr_q <= gnt_id_q;
                            if (pick_any) begin
                                gnt_q    <= pick_oh;
                                gnt_id_q <= pick_idx;
                                count_q  <= win_len;
                                last_q   <= (win_len == '0);
                            end else begin
                                state_q <= IDLE;
                                gnt_q   <= '0;
                                last_q  <= 1'b0;
                            end
                        end else begin
                            count_q <= count_q - LEN_WIDTH'(1);
                            last_q  <= (count_q == LEN_WIDTH'(1));
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.gnt_id = gnt_id_q;
    assign bus.busy   = |gnt_q;
    assign bus.last   = last_q;
endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Scoreboard bench for rr_burst_scheduler: a burst-level reference model predicts
// each cycle's outputs; a monitor pops and compares them after every clock edge.
module tb_rr_burst_scheduler;
    localparam int N  = 4;
    localparam int L  = 4;
    localparam int IW = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    rr_burst_scheduler_if #(.REQ_WIDTH(N), .LEN_WIDTH(L)) bus ();

    rr_burst_scheduler #(.REQ_WIDTH(N), .LEN_WIDTH(L)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic [IW-1:0] gid;
        logic          busy;
        logic          last;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: who owns the resource, beats left after the current one,
    // and the requester that last held it.
    int m_owner;
    int m_rem;
    int m_ptr;
    int m_gid;

    function automatic void model_reset();
        m_owner = -1;
        m_rem   = 0;
        m_ptr   = N - 1;
        m_gid   = 0;
    endfunction

    // Rotating search starting just after p; -1 if nobody requests.
    function automatic int rr_next(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (p + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic void model_step(input logic [N-1:0] r, input logic [N*L-1:0] l,
                                       input logic bd);
        int w;
        logic [N-1:0] others;
        if (m_owner < 0) begin
            w = rr_next(r, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_gid = w; m_rem = int'(l[w*L +: L]);
            end
        end else if (!r[m_owner]) begin
            m_ptr   = m_owner;
            m_owner = -1;
        end else if (bd) begin
            if (m_rem == 0) begin
                m_ptr  = m_owner;
                others = r;
                others[m_owner] = 1'b0;
                w = rr_next(others, m_ptr);
                if (w >= 0) begin
                    m_owner = w; m_gid = w; m_rem = int'(l[w*L +: L]);
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_rem = m_rem - 1;
            end
        end
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.gnt = '0;
        if (m_owner >= 0) o.gnt[m_owner] = 1'b1;
        o.gid  = IW'(m_gid);
        o.busy = (m_owner >= 0);
        o.last = (m_owner >= 0) && (m_rem == 0);
        return o;
    endfunction

    function automatic logic [N*L-1:0] mk_len(input int a, input int b, input int c, input int d);
        return {L'(d), L'(c), L'(b), L'(a)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, predict, wait for the edge, return 2 time units after it.
    task automatic step(input logic [N-1:0] r, input logic [N*L-1:0] l, input logic bd);
        bus.req       = r;
        bus.req_len   = l;
        bus.beat_done = bd;
        model_step(r, l, bd);
        exp_q.push_back(model_obs());
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        obs_t e;
        obs_t a;
        int   cyc;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.gnt, bus.gnt_id, bus.busy, bus.last};
                n_checks++;
                cyc++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard cycle %0d: got gnt=%b id=%0d busy=%b last=%b, expected gnt=%b id=%0d busy=%b last=%b",
                             cyc, a.gnt, a.gid, a.busy, a.last, e.gnt, e.gid, e.busy, e.last);
                end else begin
                    $display("cycle %0d: gnt=%b id=%0d busy=%b last=%b ok",
                             cyc, a.gnt, a.gid, a.busy, a.last);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [3:0]     seq [5];
        logic [N-1:0]   r;
        logic [N*L-1:0] l;

        bus.req = '0; bus.req_len = '0; bus.beat_done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("reset_gnt",  32'(bus.gnt), 32'h0);
        chk("reset_id",   32'(bus.gnt_id), 32'h0);
        chk("reset_busy", 32'(bus.busy), 32'h0);
        chk("reset_last", 32'(bus.last), 32'h0);
        reset_n = 1'b1;

        // All requesting, single-beat bursts: grant rotates every cycle.
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, mk_len(0, 0, 0, 0), 1'b1);
            chk("rotate_gnt",  32'(bus.gnt), 32'(seq[i]));
            chk("rotate_busy", 32'(bus.busy), 32'h1);
        end
        step(4'b0000, '0, 1'b0);

        // Four-beat burst to requester 2.
        for (int i = 0; i < 5; i++) begin
            step(4'b0100, mk_len(0, 0, 3, 0), 1'b1);
            chk("burst_gnt",  32'(bus.gnt), (i < 4) ? 32'h4 : 32'h0);
            chk("burst_last", 32'(bus.last), (i == 3) ? 32'h1 : 32'h0);
        end
        chk("burst_busy_end", 32'(bus.busy), 32'h0);
        step(4'b0000, '0, 1'b0);

        // Pointer at 1: wrap to 0, and jump to 3.
        step(4'b0010, '0, 1'b0);
        chk("ptr1_grant1", 32'(bus.gnt), 32'h2);
        step(4'b0011, '0, 1'b1);
        chk("ptr1_wrap0", 32'(bus.gnt), 32'h1);
        step(4'b0010, '0, 1'b0);
        step(4'b0010, '0, 1'b0);
        step(4'b1011, '0, 1'b1);
        chk("ptr1_next3", 32'(bus.gnt), 32'h8);
        step(4'b0000, '0, 1'b0);

        // Abort of a long burst, beat_done in the same cycle ignored.
        for (int i = 0; i < 3; i++) step(4'b0100, mk_len(0, 0, 7, 0), 1'b1);
        step(4'b1010, mk_len(0, 0, 7, 0), 1'b1);
        chk("abort_gnt", 32'(bus.gnt), 32'h0);
        step(4'b1010, '0, 1'b0);
        chk("abort_next_above", 32'(bus.gnt), 32'h8);
        step(4'b0000, '0, 1'b0);
        step(4'b0100, mk_len(0, 0, 7, 0), 1'b0);
        step(4'b0011, '0, 1'b0);
        chk("abort2_gnt", 32'(bus.gnt), 32'h0);
        step(4'b0011, '0, 1'b0);
        chk("abort_wrap", 32'(bus.gnt), 32'h1);
        step(4'b0000, '0, 1'b0);

        // Asynchronous reset in the middle of a burst.
        step(4'b0010, mk_len(0, 5, 0, 0), 1'b0);
        step(4'b0010, mk_len(0, 5, 0, 0), 1'b1);
        step(4'b0010, mk_len(0, 5, 0, 0), 1'b1);
        reset_n = 1'b0;
        #1;
        chk("async_gnt",  32'(bus.gnt), 32'h0);
        chk("async_busy", 32'(bus.busy), 32'h0);
        chk("async_last", 32'(bus.last), 32'h0);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            step(4'b1000, mk_len(0, 0, 0, 2), 1'b1);
            chk("post_reset_gnt",  32'(bus.gnt), (i < 3) ? 32'h8 : 32'h0);
            chk("post_reset_last", 32'(bus.last), (i == 2) ? 32'h1 : 32'h0);
        end
        step(4'b0000, '0, 1'b0);

        // req_len changes mid-burst have no effect; beat_done in IDLE is ignored.
        step(4'b0001, mk_len(2, 0, 0, 0), 1'b1);
        step(4'b0001, mk_len(15, 0, 0, 0), 1'b1);
        step(4'b0001, mk_len(15, 0, 0, 0), 1'b1);
        chk("len_change_last", 32'(bus.last), 32'h1);
        step(4'b0001, mk_len(15, 0, 0, 0), 1'b1);
        chk("len_change_done", 32'(bus.gnt), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, mk_len(9, 9, 9, 9), 1'b1);
            chk("idle_beat_gnt", 32'(bus.gnt), 32'h0);
        end

        // Randomized traffic against the model.
        r = '0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom);
            l = (i % 2 == 0) ? (N*L)'($urandom & 32'h3333) : (N*L)'($urandom);
            step(r, l, ($urandom_range(0, 9) < 7));
        end
        step('0, '0, 1'b0);

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
